// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl - match controller for the arcade tennis design.
//
// Debounces the start/pause buttons, sequences IDLE/SERVE/PLAY/PAUSE/OVER,
// inserts a serve delay after each point, latches the winner and issues a
// one-cycle game_rst_n pulse that restarts the ball block.
//
// Optional feature macro: PONG_PAUSE_EN
//   defined   : pause debouncer, PAUSE state and game_state=10 are built
//   undefined : btn_pause is ignored and PLAY never pauses
//
// Ports
//   clk_1ms      in   1  1 ms tick clock
//   reset        in   1  synchronous, active-low reset
//   btn_start    in   1  raw start button, active-high, asynchronous
//   btn_pause    in   1  raw pause button, active-high, asynchronous
//   p1_score     in   4  player 1 score from the ball block
//   p2_score     in   4  player 2 score from the ball block
//   game_state   out  2  00 hold, 01 play, 10 pause, 11 over
//   winner       out  2  00 none, 01 P1, 10 P2, 11 draw
//   game_rst_n   out  1  one-cycle active-low restart pulse for the ball block
//   serve_active out  1  high while serving
//
// State table
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_SERVE | ball held, serve timer counting down
//   ST_PLAY  | rally in progress, watching for points
//   ST_PAUSE | play frozen until the next pause press
//   ST_OVER  | winning score reached, winner latched

// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module pong_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_1ms,
    input  logic reset,
    input  logic btn_raw,
    output logic press_p
);
    localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'((DEBOUNCE_MS > 0) ? DEBOUNCE_MS - 1 : 0);

    logic [1:0]    sync_q;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            level   <= 1'b0;
            cnt     <= '0;
            press_p <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            press_p <= 1'b0;
            // cnt tracks how many consecutive samples disagreed with level;
            // the DEBOUNCE_MS-th disagreeing sample commits the new level.
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                level   <= sync_q[1];
                cnt     <= '0;
                press_p <= sync_q[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module pong_game_ctrl #(
    parameter int WIN_SCORE      = 7,
    parameter int DEBOUNCE_MS    = 20,
    parameter int SERVE_DELAY_MS = 1000
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    output logic [1:0] game_state,
    output logic [1:0] winner,
    output logic       game_rst_n,
    output logic       serve_active
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER
    } state_t;

    localparam int TW = (SERVE_DELAY_MS > 0) ? $clog2(SERVE_DELAY_MS + 1) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'((SERVE_DELAY_MS > 0) ? SERVE_DELAY_MS - 1 : 0);
    localparam logic [3:0]    WIN_Q    = 4'(WIN_SCORE);

    state_t        state, state_nxt;
    logic [TW-1:0] serve_tmr, serve_tmr_nxt;
    logic [3:0]    p1_prev, p2_prev;
    logic          score_chg;
    logic          point;
    logic          p1_win, p2_win;
    logic          start_p;
    logic [1:0]    game_state_nxt, winner_nxt;
    logic          game_rst_n_nxt, serve_active_nxt;

    pong_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn_raw (btn_start),
        .press_p (start_p)
    );

`ifdef PONG_PAUSE_EN
    logic pause_p;

    pong_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_pause (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn_raw (btn_pause),
        .press_p (pause_p)
    );
`else
    logic unused_btn_pause;
    assign unused_btn_pause = btn_pause;
`endif

    // score_chg is a registered difference, so a score updated at edge E is
    // acted on in cycle E+1, when p1_prev/p2_prev already hold the new score.
    assign point  = score_chg && (state == ST_PLAY);
    assign p1_win = (p1_prev >= WIN_Q);
    assign p2_win = (p2_prev >= WIN_Q);

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state        <= ST_IDLE;
            serve_tmr    <= '0;
            p1_prev      <= 4'd0;
            p2_prev      <= 4'd0;
            score_chg    <= 1'b0;
            game_state   <= 2'b00;
            winner       <= 2'b00;
            game_rst_n   <= 1'b1;
            serve_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            serve_tmr    <= serve_tmr_nxt;
            p1_prev      <= p1_score;
            p2_prev      <= p2_score;
            score_chg    <= (p1_score != p1_prev) || (p2_score != p2_prev);
            game_state   <= game_state_nxt;
            winner       <= winner_nxt;
            game_rst_n   <= game_rst_n_nxt;
            serve_active <= serve_active_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        serve_tmr_nxt  = serve_tmr;
        winner_nxt     = winner;
        game_rst_n_nxt = 1'b1;

        case (state)
            ST_IDLE: begin
                if (start_p) begin
                    state_nxt      = ST_SERVE;
                    serve_tmr_nxt  = TMR_LOAD;
                    game_rst_n_nxt = 1'b0;
                end
            end
            ST_SERVE: begin
                if (serve_tmr == '0) begin
                    state_nxt = ST_PLAY;
                end else begin
                    serve_tmr_nxt = serve_tmr - TW'(1);
                end
            end
            ST_PLAY: begin
                // A point outranks a simultaneous pause press.
                if (point) begin
                    if (p1_win || p2_win) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = {p2_win, p1_win};
                    end else begin
                        state_nxt     = ST_SERVE;
                        serve_tmr_nxt = TMR_LOAD;
                    end
                end
`ifdef PONG_PAUSE_EN
                else if (pause_p) begin
                    state_nxt = ST_PAUSE;
                end
`endif
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
                if (pause_p) begin
                    state_nxt = ST_PLAY;
                end
            end
`endif
            ST_OVER: begin
                if (start_p) begin
                    state_nxt      = ST_SERVE;
                    serve_tmr_nxt  = TMR_LOAD;
                    game_rst_n_nxt = 1'b0;
                    winner_nxt     = 2'b00;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        case (state_nxt)
            ST_PLAY:  game_state_nxt = 2'b01;
            ST_PAUSE: game_state_nxt = 2'b10;
            ST_OVER:  game_state_nxt = 2'b11;
            default:  game_state_nxt = 2'b00;
        endcase
        serve_active_nxt = (state_nxt == ST_SERVE);
    end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Match controller for the arcade tennis design, clocked on the 1 ms tick. Debounces the start/pause buttons, drives the 2-bit `game_state` consumed by the ball and paddle logic, and watches the ball block's `p1_score`/`p2_score`. From those scores it inserts a serve delay after every point, detects the winning score, and issues a one-cycle game-restart pulse that recentres the ball and clears the scores.

## Interface
Parameters:
- `WIN_SCORE`, default 7: points that end a match, range 1..15.
- `DEBOUNCE_MS`, default 20: consecutive stable cycles before a button level is accepted.
- `SERVE_DELAY_MS`, default 1000: cycles the ball is held before each serve.

Ports:
- `clk_1ms`, in, 1: 1 ms tick clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `btn_start`, in, 1: raw asynchronous start button, active-high.
- `btn_pause`, in, 1: raw asynchronous pause button, active-high.
- `p1_score`, in, 4: player 1 score from the ball block.
- `p2_score`, in, 4: player 2 score from the ball block.
- `game_state`, out, 2: encoding is 00 = hold (IDLE/SERVE), 01 = PLAY, 10 = PAUSE, 11 = OVER.
- `winner`, out, 2: 00 = none, 01 = P1, 10 = P2, 11 = draw.
- `game_rst_n`, out, 1: one-cycle active-low pulse. It is ANDed with `reset` into the ball block.
- `serve_active`, out, 1: high while in SERVE.

## Operation
- **Button conditioning:**
  - Each button passes through a 2-FF synchroniser, then a per-button stability counter.
  - The debounced level changes only after `DEBOUNCE_MS` consecutive equal samples.
  - A rising edge of the debounced level produces a one-cycle `start_p` or `pause_p`.
- **Point detection:**
  - `p1_prev` and `p2_prev` register the scores every cycle.
  - `point` = (score != prev) and the state is PLAY.
  - Score changes in any other state are ignored. This covers the clear caused by `game_rst_n`.
- **Internal states:** IDLE, SERVE, PLAY, PAUSE, OVER.
  - IDLE: reset entry. `start_p` → `game_rst_n`=0 for one cycle, load the serve timer, go to SERVE.
  - SERVE: timer counts down from `SERVE_DELAY_MS`-1. At 0 → PLAY. `pause_p` is ignored.
  - PLAY, on `point`:
    - If p1 ≥ `WIN_SCORE` or p2 ≥ `WIN_SCORE` → OVER, and latch `winner` (both → 11).
    - Otherwise → SERVE, reloading the timer.
  - PLAY, on `pause_p` with no `point` → PAUSE. If `point` and `pause_p` arrive together, `point` wins.
  - PAUSE: `pause_p` → PLAY. `start_p` is ignored.
  - OVER: `start_p` → `game_rst_n` pulse, `winner` cleared to 00, go to SERVE.
- **Serve timer:** width $clog2(`SERVE_DELAY_MS`+1). If `SERVE_DELAY_MS`=0, SERVE lasts exactly one cycle.
- **Scores:** inputs only. This block never computes scores and compares them unsigned.

## Timing
- All outputs are registered. Reset values: `game_state`=00, `winner`=00, `game_rst_n`=1, `serve_active`=0, internal state IDLE. Synchronisers and debounce counters clear to 0.
- Reset is synchronous and takes priority over every transition, including mid-SERVE and mid-debounce.
- **Button latency:** from a clean raw press to the press pulse is 2 (sync) + `DEBOUNCE_MS` cycles. Output changes one cycle after the pulse.
- **Start:**
  - `game_rst_n` is low in cycle N+1, where N is the `start_p` cycle.
  - `serve_active`=1 from N+1.
  - `game_state`=01 from N+1+`SERVE_DELAY_MS`.
- **Point:** the ball block updates a score at edge E. `point` is seen in cycle E+1, and `game_state` leaves 01 at E+2. The ball has already recentred by then.
- **Held button:** a held button produces exactly one pulse. Re-press requires a debounced release first.

## Configuration
- `PONG_PAUSE_EN` defined: the pause debouncer, the PAUSE state and `game_state`=10 are implemented.
- Undefined:
  - `btn_pause` is unused and its synchroniser and debouncer are not built.
  - PLAY never enters PAUSE and `game_state` never equals 10.

## Test plan
Benches use `DEBOUNCE_MS`=4, `SERVE_DELAY_MS`=10 and `WIN_SCORE`=3.
- Reset, no buttons for 50 cycles → `game_state`=00, `winner`=00, `game_rst_n`=1 throughout.
- `btn_start` chatters 1/0 every cycle for 3 cycles, then holds 1 → exactly one `game_rst_n` low pulse, 6 cycles after the hold begins. `game_state`=01 exactly 10 cycles after the pulse.
- In PLAY, `p1_score` 0→1 → `game_state`=00 and `serve_active`=1 two cycles later. Back to 01 after 10 more cycles.
- In PLAY, `p2_score` 2→3 → `game_state`=11 and `winner`=10. Then `btn_start` → `game_rst_n` pulse, `winner`=00, SERVE, then PLAY.
- With `PONG_PAUSE_EN`: a pause press in PLAY → 10, a second press → 01. Pause pressed during SERVE → no effect. Without the macro: pause press in PLAY → stays 01.
- `reset` asserted low mid-SERVE at timer=5 → next cycle `game_state`=00, `serve_active`=0, IDLE. `btn_start` is required to restart.
